// File: rtl/memory_stage_pkg.sv
// Shared types and constants for the memory stage: FSM state encoding and
// timeout counter sizing.
package memory_stage_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam int unsigned MEM_TIMEOUT_DEFAULT = 15;

  // Counter must be able to hold MEM_TIMEOUT itself.
  function automatic int unsigned timer_width(input int unsigned timeout);
    return $clog2(timeout + 1);
  endfunction

  localparam int unsigned TIMER_W_DEFAULT = $clog2(MEM_TIMEOUT_DEFAULT + 1);

endpackage

// File: rtl/memory_stage_if.sv
// Data-memory bus between the memory stage (master) and the memory (slave).
interface memory_stage_if #(
  parameter int unsigned REG_WIDTH = 16
);

  logic [REG_WIDTH-1:0] o_R_mem_addr;
  logic [REG_WIDTH-1:0] o_R_mem_wdata;
  logic                 o_1_mem_req;
  logic                 o_1_mem_we;
  logic                 i_1_mem_ack;
  logic [REG_WIDTH-1:0] i_R_mem_rdata;

  modport master (
    output o_R_mem_addr,
    output o_R_mem_wdata,
    output o_1_mem_req,
    output o_1_mem_we,
    input  i_1_mem_ack,
    input  i_R_mem_rdata
  );

  modport slave (
    input  o_R_mem_addr,
    input  o_R_mem_wdata,
    input  o_1_mem_req,
    input  o_1_mem_we,
    output i_1_mem_ack,
    output i_R_mem_rdata
  );

endinterface

// File: rtl/memory_stage_mem_timer.sv
// Access timeout counter: cleared at request start, counts un-acked request
// cycles, flags the cycle whose increment reaches MEM_TIMEOUT.
module mem_timer
  import memory_stage_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CNT_W = timer_width(MEM_TIMEOUT);

  logic [CNT_W-1:0] count;

  // Expiry is the cycle that would bring the count to MEM_TIMEOUT, so the
  // request stays high for exactly MEM_TIMEOUT cycles.
  assign expired = enable && (count == CNT_W'(MEM_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable && (count != CNT_W'(MEM_TIMEOUT))) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/memory_stage.sv
// Pipeline memory stage: issues one data-memory access per load/store,
// stalls upstream until it completes or times out, then retires to writeback.
module memory_stage
  import memory_stage_pkg::*;
#(
  parameter int unsigned REG_WIDTH   = 16,
  parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_1_alu_zero,
  input  logic [REG_WIDTH-1:0] i_R_alu_out,
  input  logic [REG_WIDTH-1:0] i_R_wr_data,
  input  logic [3:0]           i_4_reg_wr_addr,
  input  logic [REG_WIDTH-1:0] i_R_pc_branch,
  input  logic                 i_1_mem_addr_sel,
  input  logic                 i_1_reg_wr_en,
  input  logic                 i_1_mem2reg_sel,
  input  logic                 i_1_mem_wr_en,
  input  logic                 i_1_branch,
  output logic                 o_1_stall,
  output logic [REG_WIDTH-1:0] or_R_wb_data,
  output logic [3:0]           or_4_wb_addr,
  output logic                 or_1_wb_en,
  output logic                 or_1_pc_src,
  output logic [REG_WIDTH-1:0] or_R_pc_target,
  output logic                 or_1_mem_err,
  memory_stage_if.master       mem
);

  state_t state;
  state_t state_next;

  logic                 access;
  logic [REG_WIDTH-1:0] access_addr;
  logic                 stall;
  logic                 start;
  logic                 retire;
  logic                 ack_ok;
  logic                 timer_en;
  logic                 timer_expired;
  logic                 timed_out;
  logic [REG_WIDTH-1:0] hold;
  logic                 load_wb;

  assign access      = i_1_mem_wr_en | i_1_mem2reg_sel;
  assign access_addr = i_1_mem_addr_sel ? i_R_alu_out : i_R_wr_data;
  // Store wins when both are set, so writeback takes the ALU result.
  assign load_wb     = i_1_mem2reg_sel & ~i_1_mem_wr_en;

  mem_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_mem_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (start),
    .enable (timer_en),
    .expired(timer_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    stall      = 1'b0;
    start      = 1'b0;
    retire     = 1'b0;
    ack_ok     = 1'b0;
    timer_en   = 1'b0;
    case (state)
      IDLE: begin
        if (access) begin
          state_next = ACCESS;
          stall      = 1'b1;
          start      = 1'b1;
        end else begin
          retire = 1'b1;
        end
      end
      ACCESS: begin
        stall    = 1'b1;
        ack_ok   = mem.i_1_mem_ack;
        timer_en = ~mem.i_1_mem_ack;
        if (mem.i_1_mem_ack || timer_expired) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
        retire     = 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  assign o_1_stall       = stall;
  assign mem.o_1_mem_req = (state == ACCESS);

  always_ff @(posedge clk) begin
    if (rst) begin
      mem.o_R_mem_addr  <= '0;
      mem.o_R_mem_wdata <= '0;
      mem.o_1_mem_we    <= 1'b0;
      hold              <= '0;
      timed_out         <= 1'b0;
      or_1_mem_err      <= 1'b0;
      or_R_wb_data      <= '0;
      or_4_wb_addr      <= '0;
      or_1_wb_en        <= 1'b0;
      or_1_pc_src       <= 1'b0;
      or_R_pc_target    <= '0;
    end else begin
      if (start) begin
        mem.o_R_mem_addr  <= access_addr;
        mem.o_R_mem_wdata <= i_R_wr_data;
        mem.o_1_mem_we    <= i_1_mem_wr_en;
        timed_out         <= 1'b0;
      end

      if (ack_ok) begin
        hold <= mem.i_R_mem_rdata;
      end else if (timer_expired) begin
        hold         <= '0;
        timed_out    <= 1'b1;
        or_1_mem_err <= 1'b1;
      end

      // timed_out is only meaningful for the instruction retiring from DONE.
      if (retire) begin
        or_R_wb_data   <= load_wb ? hold : i_R_alu_out;
        or_4_wb_addr   <= i_4_reg_wr_addr;
        or_1_wb_en     <= i_1_reg_wr_en & ~((state == DONE) & timed_out);
        or_1_pc_src    <= i_1_branch & i_1_alu_zero;
        or_R_pc_target <= i_R_pc_branch;
      end else begin
        or_1_wb_en  <= 1'b0;
        or_1_pc_src <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// Randomized self-checking bench for memory_stage against a per-instruction
// reference model (timing derived from ack delay and timeout).
module tb_memory_stage;

  localparam int unsigned RW = 16;
  localparam int unsigned TO = 15;

  typedef struct {
    logic          zero;
    logic          addr_sel;
    logic          reg_wr_en;
    logic          m2r;
    logic          wr_en;
    logic          branch;
    logic [RW-1:0] alu;
    logic [RW-1:0] wdat;
    logic [RW-1:0] pcb;
    logic [3:0]    rd;
  } instr_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_1_alu_zero;
  logic [RW-1:0] i_R_alu_out;
  logic [RW-1:0] i_R_wr_data;
  logic [3:0]    i_4_reg_wr_addr;
  logic [RW-1:0] i_R_pc_branch;
  logic          i_1_mem_addr_sel;
  logic          i_1_reg_wr_en;
  logic          i_1_mem2reg_sel;
  logic          i_1_mem_wr_en;
  logic          i_1_branch;
  logic          o_1_stall;
  logic [RW-1:0] or_R_wb_data;
  logic [3:0]    or_4_wb_addr;
  logic          or_1_wb_en;
  logic          or_1_pc_src;
  logic [RW-1:0] or_R_pc_target;
  logic          or_1_mem_err;

  int checks_total  = 0;
  int checks_passed = 0;
  logic err_exp = 1'b0;

  memory_stage_if #(.REG_WIDTH(RW)) mem_bus ();

  memory_stage #(
    .REG_WIDTH  (RW),
    .MEM_TIMEOUT(TO)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .i_1_alu_zero    (i_1_alu_zero),
    .i_R_alu_out     (i_R_alu_out),
    .i_R_wr_data     (i_R_wr_data),
    .i_4_reg_wr_addr (i_4_reg_wr_addr),
    .i_R_pc_branch   (i_R_pc_branch),
    .i_1_mem_addr_sel(i_1_mem_addr_sel),
    .i_1_reg_wr_en   (i_1_reg_wr_en),
    .i_1_mem2reg_sel (i_1_mem2reg_sel),
    .i_1_mem_wr_en   (i_1_mem_wr_en),
    .i_1_branch      (i_1_branch),
    .o_1_stall       (o_1_stall),
    .or_R_wb_data    (or_R_wb_data),
    .or_4_wb_addr    (or_4_wb_addr),
    .or_1_wb_en      (or_1_wb_en),
    .or_1_pc_src     (or_1_pc_src),
    .or_R_pc_target  (or_R_pc_target),
    .or_1_mem_err    (or_1_mem_err),
    .mem             (mem_bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [RW-1:0] got, input logic [RW-1:0] exp);
    checks_total++;
    if (got === exp) begin
      checks_passed++;
    end else begin
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input instr_t ins);
    i_1_alu_zero     = ins.zero;
    i_R_alu_out      = ins.alu;
    i_R_wr_data      = ins.wdat;
    i_4_reg_wr_addr  = ins.rd;
    i_R_pc_branch    = ins.pcb;
    i_1_mem_addr_sel = ins.addr_sel;
    i_1_reg_wr_en    = ins.reg_wr_en;
    i_1_mem2reg_sel  = ins.m2r;
    i_1_mem_wr_en    = ins.wr_en;
    i_1_branch       = ins.branch;
  endtask

  function automatic instr_t blank();
    instr_t ins;
    ins.zero = 1'b0; ins.addr_sel = 1'b0; ins.reg_wr_en = 1'b0; ins.m2r = 1'b0;
    ins.wr_en = 1'b0; ins.branch = 1'b0; ins.alu = '0; ins.wdat = '0;
    ins.pcb = '0; ins.rd = '0;
    return ins;
  endfunction

  // ack_delay: request cycle (1-based) carrying ack; above TO means never acked.
  task automatic run_instr(input instr_t ins, input int unsigned ack_delay, input logic [RW-1:0] rdata);
    logic          access;
    logic          success;
    int unsigned   n;
    logic [RW-1:0] exp_addr;
    logic [RW-1:0] exp_data;
    access = ins.wr_en | ins.m2r;
    apply(ins);
    mem_bus.i_1_mem_ack   = 1'($urandom_range(0, 1));
    mem_bus.i_R_mem_rdata = RW'($urandom);
    #1;
    check("stall_issue", 16'(o_1_stall), 16'(access));
    if (!access) begin
      step();
      mem_bus.i_1_mem_ack = 1'b0;
      check("req_alu", 16'(mem_bus.o_1_mem_req), 16'd0);
      check("wb_en_alu", 16'(or_1_wb_en), 16'(ins.reg_wr_en));
      check("wb_data_alu", or_R_wb_data, ins.alu);
      check("wb_addr_alu", 16'(or_4_wb_addr), 16'(ins.rd));
      check("pc_src_alu", 16'(or_1_pc_src), 16'(ins.branch & ins.zero));
      check("pc_target_alu", or_R_pc_target, ins.pcb);
      return;
    end
    success  = (ack_delay >= 1) && (ack_delay <= TO);
    n        = success ? ack_delay : TO;
    exp_addr = ins.addr_sel ? ins.alu : ins.wdat;
    step();
    for (int unsigned k = 1; k <= n; k++) begin
      check("req_access", 16'(mem_bus.o_1_mem_req), 16'd1);
      check("mem_addr", mem_bus.o_R_mem_addr, exp_addr);
      check("mem_wdata", mem_bus.o_R_mem_wdata, ins.wdat);
      check("mem_we", 16'(mem_bus.o_1_mem_we), 16'(ins.wr_en));
      check("wb_en_bubble", 16'(or_1_wb_en), 16'd0);
      check("pc_src_bubble", 16'(or_1_pc_src), 16'd0);
      mem_bus.i_1_mem_ack   = (k == ack_delay);
      mem_bus.i_R_mem_rdata = (k == ack_delay) ? rdata : RW'($urandom);
      #1;
      check("stall_access", 16'(o_1_stall), 16'd1);
      step();
    end
    if (!success) err_exp = 1'b1;
    check("req_done", 16'(mem_bus.o_1_mem_req), 16'd0);
    check("wb_en_done", 16'(or_1_wb_en), 16'd0);
    check("mem_err_done", 16'(or_1_mem_err), 16'(err_exp));
    mem_bus.i_1_mem_ack   = 1'($urandom_range(0, 1));
    mem_bus.i_R_mem_rdata = RW'($urandom);
    #1;
    check("stall_done", 16'(o_1_stall), 16'd0);
    step();
    mem_bus.i_1_mem_ack = 1'b0;
    exp_data = (ins.m2r && !ins.wr_en) ? (success ? rdata : '0) : ins.alu;
    check("wb_en_mem", 16'(or_1_wb_en), 16'(ins.reg_wr_en & success));
    check("wb_data_mem", or_R_wb_data, exp_data);
    check("wb_addr_mem", 16'(or_4_wb_addr), 16'(ins.rd));
    check("pc_src_mem", 16'(or_1_pc_src), 16'(ins.branch & ins.zero));
    check("pc_target_mem", or_R_pc_target, ins.pcb);
    check("mem_err_retire", 16'(or_1_mem_err), 16'(err_exp));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req"}, 16'(mem_bus.o_1_mem_req), 16'd0);
    check({tag, "_we"}, 16'(mem_bus.o_1_mem_we), 16'd0);
    check({tag, "_addr"}, mem_bus.o_R_mem_addr, 16'd0);
    check({tag, "_wdata"}, mem_bus.o_R_mem_wdata, 16'd0);
    check({tag, "_wb_en"}, 16'(or_1_wb_en), 16'd0);
    check({tag, "_wb_data"}, or_R_wb_data, 16'd0);
    check({tag, "_wb_addr"}, 16'(or_4_wb_addr), 16'd0);
    check({tag, "_pc_src"}, 16'(or_1_pc_src), 16'd0);
    check({tag, "_pc_target"}, or_R_pc_target, 16'd0);
    check({tag, "_mem_err"}, 16'(or_1_mem_err), 16'd0);
    check({tag, "_stall"}, 16'(o_1_stall), 16'd0);
  endtask

  initial begin
    instr_t ins;
    int unsigned d;
    rst = 1'b1;
    apply(blank());
    mem_bus.i_1_mem_ack   = 1'b0;
    mem_bus.i_R_mem_rdata = '0;
    step();
    step();
    check_all_zero("reset");
    rst = 1'b0;

    ins = blank(); ins.alu = 16'h1234; ins.reg_wr_en = 1'b1; ins.rd = 4'd3;
    run_instr(ins, 0, '0);

    ins = blank(); ins.addr_sel = 1'b1; ins.alu = 16'h0040; ins.m2r = 1'b1;
    ins.reg_wr_en = 1'b1; ins.rd = 4'd5; ins.wdat = 16'h1111;
    run_instr(ins, 3, 16'hBEEF);

    ins = blank(); ins.wdat = 16'h0080; ins.wr_en = 1'b1; ins.alu = 16'h0055;
    ins.reg_wr_en = 1'b1; ins.rd = 4'd7;
    run_instr(ins, 2, 16'h2222);

    ins = blank(); ins.addr_sel = 1'b1; ins.alu = 16'h0010; ins.m2r = 1'b1;
    ins.reg_wr_en = 1'b1; ins.rd = 4'd2;
    run_instr(ins, TO, 16'hCAFE);

    ins = blank(); ins.wr_en = 1'b1; ins.m2r = 1'b1; ins.alu = 16'h00AA;
    ins.wdat = 16'h0C0C; ins.reg_wr_en = 1'b1; ins.rd = 4'd9;
    run_instr(ins, 1, 16'h5A5A);

    ins = blank(); ins.branch = 1'b1; ins.zero = 1'b1; ins.pcb = 16'h0102;
    run_instr(ins, 0, '0);
    ins.zero = 1'b0;
    run_instr(ins, 0, '0);

    ins = blank(); ins.addr_sel = 1'b1; ins.alu = 16'h0020; ins.m2r = 1'b1;
    ins.reg_wr_en = 1'b1; ins.rd = 4'd4;
    run_instr(ins, TO + 1, 16'hDEAD);

    for (int i = 0; i < 40; i++) begin
      ins.zero      = 1'($urandom_range(0, 1));
      ins.addr_sel  = 1'($urandom_range(0, 1));
      ins.reg_wr_en = 1'($urandom_range(0, 1));
      ins.m2r       = 1'($urandom_range(0, 1));
      ins.wr_en     = 1'($urandom_range(0, 1));
      ins.branch    = 1'($urandom_range(0, 1));
      ins.alu       = RW'($urandom);
      ins.wdat      = RW'($urandom);
      ins.pcb       = RW'($urandom);
      ins.rd        = 4'($urandom);
      case ($urandom_range(0, 9))
        0:       d = TO + 1 + $urandom_range(0, 2);
        1:       d = $urandom_range(TO - 1, TO);
        default: d = $urandom_range(1, 5);
      endcase
      run_instr(ins, d, RW'($urandom));
    end

    // Reset in the middle of an access: request drops, nothing retires.
    ins = blank(); ins.addr_sel = 1'b1; ins.alu = 16'h0300; ins.m2r = 1'b1;
    ins.reg_wr_en = 1'b1; ins.rd = 4'd6; ins.branch = 1'b1; ins.zero = 1'b1;
    ins.pcb = 16'h0400;
    apply(ins);
    mem_bus.i_1_mem_ack = 1'b0;
    step();
    for (int k = 0; k < 3; k++) begin
      check("req_pre_rst", 16'(mem_bus.o_1_mem_req), 16'd1);
      step();
    end
    rst = 1'b1;
    apply(blank());
    step();
    err_exp = 1'b0;
    check_all_zero("rst_access");
    rst = 1'b0;
    mem_bus.i_1_mem_ack   = 1'b1;
    mem_bus.i_R_mem_rdata = 16'h7777;
    step();
    check("late_ack_req", 16'(mem_bus.o_1_mem_req), 16'd0);
    check("late_ack_wb_en", 16'(or_1_wb_en), 16'd0);
    check("late_ack_err", 16'(or_1_mem_err), 16'd0);
    mem_bus.i_1_mem_ack = 1'b0;
    step();
    check("late_ack_req2", 16'(mem_bus.o_1_mem_req), 16'd0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
